// File: rtl/tdm_demux4.sv
// tdm_demux4: serial 4-slot TDM demultiplexer with frame-lock FSM and sync-error detection.
// Optional macro TDM_DEMUX_PARITY_EN appends an even-parity bit to every slot and adds parity_err.
module tdm_demux4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               din,
    input  logic               frame_sync,
    output logic [4*WIDTH-1:0] data_out,
    output logic [3:0]         ch_valid,
    output logic               frame_done,
    output logic               locked,
`ifdef TDM_DEMUX_PARITY_EN
    output logic               sync_err,
    output logic               parity_err
`else
    output logic               sync_err
`endif
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned SLOT_BITS = WIDTH + 1;
    localparam int unsigned SHIFT_W   = WIDTH;
`else
    localparam int unsigned SLOT_BITS = WIDTH;
    localparam int unsigned SHIFT_W   = WIDTH - 1;
`endif
    localparam int unsigned CNT_W = $clog2(SLOT_BITS);
    localparam int unsigned LAST  = SLOT_BITS - 1;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d, shifted;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]           slot_cnt_q, slot_cnt_d;
    logic [4*WIDTH-1:0]   data_d;
    logic [3:0]           ch_valid_d;
    logic                 frame_done_d;
    logic                 sync_err_d;
    logic                 at_start;
    logic [WIDTH-1:0]     word;
`ifdef TDM_DEMUX_PARITY_EN
    logic                 parity_err_d;
`endif

    // Only the most recent bits of the shift history are kept; older bits fall off the top.
    assign shifted  = SHIFT_W'({shift_q, din});
    assign at_start = (bit_cnt_q == '0) && (slot_cnt_q == 2'd0);
`ifdef TDM_DEMUX_PARITY_EN
    assign word = shift_q;
`else
    assign word = {shift_q, din};
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            slot_cnt_q <= '0;
            data_out   <= '0;
            ch_valid   <= '0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            data_out   <= data_d;
            ch_valid   <= ch_valid_d;
            frame_done <= frame_done_d;
            locked     <= (state_d == LOCK);
            sync_err   <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err <= parity_err_d;
`endif
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        slot_cnt_d   = slot_cnt_q;
        data_d       = data_out;
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (en) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        state_d    = LOCK;
                        shift_d    = shifted;
                        bit_cnt_d  = CNT_W'(1);
                        slot_cnt_d = 2'd0;
                    end
                end
                LOCK: begin
                    if (at_start && !frame_sync) begin
                        // Missing sync wins over everything else at the frame start.
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        bit_cnt_d  = '0;
                        slot_cnt_d = 2'd0;
                    end else if (!at_start && frame_sync) begin
                        sync_err_d = 1'b1;
                        shift_d    = shifted;
                        bit_cnt_d  = CNT_W'(1);
                        slot_cnt_d = 2'd0;
                    end else begin
                        shift_d = shifted;
                        if (bit_cnt_q == CNT_W'(LAST)) begin
                            bit_cnt_d    = '0;
                            slot_cnt_d   = slot_cnt_q + 2'd1;
                            ch_valid_d   = 4'b0001 << slot_cnt_q;
                            frame_done_d = (slot_cnt_q == 2'd3);
                            for (int unsigned k = 0; k < 4; k++) begin
                                if (slot_cnt_q == 2'(k)) begin
                                    data_d[k*WIDTH +: WIDTH] = word;
                                end
                            end
`ifdef TDM_DEMUX_PARITY_EN
                            parity_err_d = ^{shift_q, din};
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: frame vector table, corner-case sequences and a
// randomized run against a position-based reference model (honours TDM_DEMUX_PARITY_EN).
module tb_tdm_demux4;
    localparam int unsigned W = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned SB = W + 1;
`else
    localparam int unsigned SB = W;
`endif

    logic           clk = 1'b0;
    logic           rst, en, din, frame_sync;
    logic [4*W-1:0] data_out;
    logic [3:0]     ch_valid;
    logic           frame_done, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic           parity_err;
`endif

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .frame_sync (frame_sync),
        .data_out   (data_out),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .locked     (locked),
`ifdef TDM_DEMUX_PARITY_EN
        .sync_err   (sync_err),
        .parity_err (parity_err)
`else
        .sync_err   (sync_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame position counter plus the integer value of the current slot.
    bit             m_locked;
    int             m_pos;
    int             m_cur;
    logic [4*W-1:0] m_data;
    logic [3:0]     m_valid;
    bit             m_done, m_serr, m_perr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic d, input logic f);
        int slot;
        m_valid = '0;
        m_done  = 1'b0;
        m_serr  = 1'b0;
        m_perr  = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_pos    = 0;
            m_cur    = 0;
            m_data   = '0;
            return;
        end
        if (!e) return;
        if (!m_locked) begin
            if (f) begin
                m_locked = 1'b1;
                m_pos    = 1;
                m_cur    = int'(d);
            end
        end else if (m_pos == 0 && !f) begin
            m_serr   = 1'b1;
            m_locked = 1'b0;
        end else if (m_pos != 0 && f) begin
            m_serr = 1'b1;
            m_pos  = 1;
            m_cur  = int'(d);
        end else begin
            m_cur = (m_pos % SB == 0) ? int'(d) : m_cur * 2 + int'(d);
            m_pos++;
            if (m_pos % SB == 0) begin
                slot = m_pos / SB - 1;
                m_valid[slot] = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                m_data[slot*W +: W] = W'(m_cur >> 1);
                m_perr = ($countones(m_cur) % 2) != 0;
`else
                m_data[slot*W +: W] = W'(m_cur);
`endif
                if (slot == 3) begin
                    m_done = 1'b1;
                    m_pos  = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic d, input logic f);
        rst = r; en = e; din = d; frame_sync = f;
        @(posedge clk);
        #1;
        model(r, e, d, f);
        chk("data_out", data_out, m_data);
        chk("ch_valid", ch_valid, m_valid);
        chk("frame_done", frame_done, m_done);
        chk("locked", locked, m_locked);
        chk("sync_err", sync_err, m_serr);
`ifdef TDM_DEMUX_PARITY_EN
        chk("parity_err", parity_err, m_perr);
`endif
    endtask

    // Sends bits [from..SB-1] of one slot; optional 3-cycle en gaps after every second bit.
    task automatic send_word(input logic [W-1:0] w, input bit first, input bit gaps,
                             input bit bad_par, input int slot, input int from);
        for (int i = from; i < SB; i++) begin
            logic b;
            if (i < W) b = w[W-1-i];
            else       b = (^w) ^ bad_par;
            step(1'b0, 1'b1, b, first && (i == 0));
            if (i == SB - 1 && slot >= 0) begin
                chk("hand_ch_valid", ch_valid, 4'b0001 << slot);
                chk("hand_word", data_out[slot*W +: W], w);
            end
            if (gaps && (i % 2 == 1) && i < SB - 1)
                repeat (3) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic send_frame(input logic [4*W-1:0] f, input bit gaps);
        for (int k = 0; k < 4; k++)
            send_word(f[k*W +: W], k == 0, gaps, 1'b0, k, 0);
    endtask

    typedef struct {
        logic [4*W-1:0] words;
        bit             gaps;
        logic [4*W-1:0] exp_data;
        logic           exp_locked;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int tpos;
        vecs[0] = '{words: 32'h01FF3CA5, gaps: 1'b0, exp_data: 32'h01FF3CA5, exp_locked: 1'b1};
        vecs[1] = '{words: 32'h12345678, gaps: 1'b1, exp_data: 32'h12345678, exp_locked: 1'b1};
        vecs[2] = '{words: 32'h01FF3CA5, gaps: 1'b1, exp_data: 32'h01FF3CA5, exp_locked: 1'b1};
        vecs[3] = '{words: 32'hDEADBEEF, gaps: 1'b0, exp_data: 32'hDEADBEEF, exp_locked: 1'b1};
        rst = 1'b1; en = 1'b0; din = 1'b0; frame_sync = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_data", data_out, 0);
        chk("reset_locked", locked, 0);
        repeat (50) step(1'b0, 1'b1, 1'($urandom), 1'b0);
        chk("idle_locked", locked, 0);
        chk("idle_data", data_out, 0);

        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].words, vecs[v].gaps);
            chk("vec_data", data_out, vecs[v].exp_data);
            chk("vec_done", frame_done, 1);
            chk("vec_valid", ch_valid, 4'b1000);
            chk("vec_locked", locked, vecs[v].exp_locked);
        end

        // Sync arriving at slot 1 bit 4 restarts the frame.
        send_word(8'h55, 1'b1, 1'b0, 1'b0, 0, 0);
        repeat (4) step(1'b0, 1'b1, 1'($urandom), 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("misalign_err", sync_err, 1);
        chk("misalign_locked", locked, 1);
        chk("misalign_valid", ch_valid, 0);
        send_word(8'h11, 1'b0, 1'b0, 1'b0, 0, 1);
        send_word(8'h22, 1'b0, 1'b0, 1'b0, 1, 0);
        send_word(8'h33, 1'b0, 1'b0, 1'b0, 2, 0);
        send_word(8'h44, 1'b0, 1'b0, 1'b0, 3, 0);
        chk("misalign_data", data_out, 32'h44332211);

        // Missing sync at the frame start drops lock, data holds, then relock.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("missing_err", sync_err, 1);
        chk("missing_locked", locked, 0);
        chk("missing_hold", data_out, 32'h44332211);
        repeat (5) step(1'b0, 1'b1, 1'($urandom), 1'b0);
        send_frame(32'hCAFEF00D, 1'b0);
        chk("relock_data", data_out, 32'hCAFEF00D);

        // Reset after 12 bits of a frame.
        send_word(8'h96, 1'b1, 1'b0, 1'b0, 0, 0);
        repeat (12 - SB) step(1'b0, 1'b1, 1'($urandom), 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst_data", data_out, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_valid", ch_valid, 0);
`ifdef TDM_DEMUX_PARITY_EN
        send_word(8'hA1, 1'b1, 1'b0, 1'b0, 0, 0);
        send_word(8'hB2, 1'b0, 1'b0, 1'b0, 1, 0);
        send_word(8'h07, 1'b0, 1'b0, 1'b1, 2, 0);
        chk("parity_err_pulse", parity_err, 1);
        chk("parity_valid", ch_valid, 4'b0100);
        chk("parity_data", data_out[23:16], 8'h07);
        send_word(8'hC3, 1'b0, 1'b0, 1'b0, 3, 0);
        chk("parity_clean", parity_err, 0);
`endif

        // Randomized traffic: mostly aligned syncs, occasional stray syncs and resets.
        tpos = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4000; c++) begin
            logic r, e, d, f;
            r = ($urandom_range(0, 499) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = 1'($urandom);
            f = (tpos == 0) ^ ($urandom_range(0, 63) == 0);
            step(r, e, d, f);
            if (r) tpos = 0;
            else if (e) tpos = (tpos + 1) % (4 * SB);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
